// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants up to NUM_CDB of NUM_REQ FU completions per cycle and registers them onto the CDB.
// Define CDB_ARB_STARVE_GUARD_EN to add per-requester wait counters that force-prioritise starved requesters.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned NUM_CDB = 3,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned ROB_W   = 5,
    parameter int unsigned XLEN    = 32
`ifdef CDB_ARB_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_LIMIT = 4
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    input  logic [NUM_REQ*XLEN-1:0]  req_value,
    input  logic [NUM_REQ*ROB_W-1:0] req_rob,
    output logic [NUM_REQ-1:0]       req_grant,
    output logic [NUM_REQ-1:0]       req_stall,
    output logic [NUM_CDB-1:0]       cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    output logic [NUM_CDB*XLEN-1:0]  cdb_value,
    output logic [NUM_CDB*ROB_W-1:0] cdb_rob
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]         rr_ptr_nxt;
    logic [NUM_REQ-1:0]       grant_c;
    logic [NUM_REQ-1:0]       urgent;
    logic [NUM_CDB-1:0]       slot_used;
    logic [PTR_W-1:0]         slot_idx [NUM_CDB];
    logic                     normal_hit;
    logic [PTR_W-1:0]         last_normal;
    logic [NUM_CDB*TAG_W-1:0] nxt_tag;
    logic [NUM_CDB*XLEN-1:0]  nxt_value;
    logic [NUM_CDB*ROB_W-1:0] nxt_rob;

    // (base + ofs) mod NUM_REQ, ofs < NUM_REQ
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int unsigned ofs);
        int unsigned sum;
        sum = 32'(base) + ofs;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return PTR_W'(sum);
    endfunction

`ifdef CDB_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] wait_cnt [NUM_REQ];

    always_comb begin
        urgent = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            urgent[i] = req_valid[i] && (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    // Saturating stall counters; any grant or dropped valid clears them
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || grant_c[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
                    wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    assign urgent = '0;
`endif

    // Pass 0 takes urgent requesters, pass 1 is the normal round-robin scan; k-th grant fills slot NUM_CDB-1-k
    always_comb begin
        int unsigned      n;
        logic [PTR_W-1:0] idx;
        logic             take;
        grant_c     = '0;
        slot_used   = '0;
        normal_hit  = 1'b0;
        last_normal = '0;
        n           = 0;
        idx         = '0;
        take        = 1'b0;
        for (int unsigned s = 0; s < NUM_CDB; s++) begin
            slot_idx[s] = '0;
        end
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx  = rr_idx(rr_ptr, k);
                take = (p == 0) ? urgent[idx] : (req_valid[idx] && !grant_c[idx]);
                if (take && (n < NUM_CDB)) begin
                    grant_c[idx] = 1'b1;
                    for (int unsigned s = 0; s < NUM_CDB; s++) begin
                        if (s == NUM_CDB - 1 - n) begin
                            slot_used[s] = 1'b1;
                            slot_idx[s]  = idx;
                        end
                    end
                    n = n + 1;
                    if (p == 1) begin
                        normal_hit  = 1'b1;
                        last_normal = idx;
                    end
                end
            end
        end
    end

    assign rr_ptr_nxt = normal_hit ? rr_idx(last_normal, 1) : rr_ptr;
    assign req_grant  = (rst && !flush) ? grant_c : '0;
    assign req_stall  = rst ? (req_valid & ~req_grant) : '0;

    // Payload copy into slots; unused slots carry zeros
    always_comb begin
        nxt_tag   = '0;
        nxt_value = '0;
        nxt_rob   = '0;
        for (int unsigned s = 0; s < NUM_CDB; s++) begin
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
                if (slot_used[s] && (slot_idx[s] == PTR_W'(r))) begin
                    nxt_tag[s*TAG_W +: TAG_W]  = req_tag[r*TAG_W +: TAG_W];
                    nxt_value[s*XLEN +: XLEN]  = req_value[r*XLEN +: XLEN];
                    nxt_rob[s*ROB_W +: ROB_W]  = req_rob[r*ROB_W +: ROB_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rr_ptr    <= '0;
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_rob   <= '0;
        end else begin
            rr_ptr    <= rr_ptr_nxt;
            cdb_valid <= slot_used;
            cdb_tag   <= nxt_tag;
            cdb_value <= nxt_value;
            cdb_rob   <= nxt_rob;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: driver checks same-cycle grants and queues expected CDB contents for a monitor.
// A single-slot instance provides the starvation scenario.
`timescale 1ns/1ps
module tb_cdb_arbiter;
    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned NUM_CDB = 3;
    localparam int unsigned TAG_W   = 6;
    localparam int unsigned ROB_W   = 5;
    localparam int unsigned XLEN    = 32;
    localparam logic [3:0]  NONE    = 4'hF;

    typedef struct packed {
        logic [31:0] due;
        logic        dut1;
        logic [3:0]  f2;
        logic [3:0]  f1;
        logic [3:0]  f0;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [NUM_REQ*XLEN-1:0]  req_value;
    logic [NUM_REQ*ROB_W-1:0] req_rob;
    logic [NUM_REQ-1:0]       req_grant, req_stall;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_value;
    logic [NUM_CDB*ROB_W-1:0] cdb_rob;
    logic [NUM_REQ-1:0]       g1, s1;
    logic [0:0]               c1_valid;
    logic [TAG_W-1:0]         c1_tag;
    logic [XLEN-1:0]          c1_value;
    logic [ROB_W-1:0]         c1_rob;

    int unsigned cyc    = 0;
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    exp_t        exp_q[$];
    exp_t        cur;

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .ROB_W(ROB_W), .XLEN(XLEN)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value), .req_rob(req_rob),
        .req_grant(req_grant), .req_stall(req_stall),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_rob(cdb_rob)
    );

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .NUM_CDB(1), .TAG_W(TAG_W), .ROB_W(ROB_W), .XLEN(XLEN)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value), .req_rob(req_rob),
        .req_grant(g1), .req_stall(s1),
        .cdb_valid(c1_valid), .cdb_tag(c1_tag), .cdb_value(c1_value), .cdb_rob(c1_rob)
    );

    function automatic logic [TAG_W-1:0] tag_of(input int unsigned i);
        return TAG_W'(i + 1);
    endfunction

    function automatic logic [XLEN-1:0] value_of(input int unsigned i);
        return 32'h1234_5678 + (32'(i) * 32'h0101_0101);
    endfunction

    function automatic logic [ROB_W-1:0] rob_of(input int unsigned i);
        return ROB_W'(10 + i);
    endfunction

    // {valid, tag, value, rob} that a slot holding FU fu must show
    function automatic logic [63:0] slot_exp(input logic [3:0] fu);
        if (fu == NONE) return 64'd0;
        return 64'({1'b1, tag_of(32'(fu)), value_of(32'(fu)), rob_of(32'(fu))});
    endfunction

    task automatic check(input string name, input int unsigned at, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, at, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare CDB outputs against every expectation due this cycle
    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            cur = exp_q.pop_front();
            if (cur.due != cyc) begin
                check("late", cyc, 64'(cyc), 64'(cur.due));
            end else if (cur.dut1) begin
                check("cdb1 slot0", cyc, 64'({c1_valid[0], c1_tag, c1_value, c1_rob}), slot_exp(cur.f0));
            end else begin
                for (int s = 0; s < 3; s++) begin
                    check($sformatf("cdb slot%0d", s), cyc,
                          64'({cdb_valid[s], cdb_tag[s*TAG_W +: TAG_W], cdb_value[s*XLEN +: XLEN], cdb_rob[s*ROB_W +: ROB_W]}),
                          slot_exp((s == 2) ? cur.f2 : (s == 1) ? cur.f1 : cur.f0));
                end
            end
        end
    end

    // One cycle of stimulus: same-cycle grant/stall checks, CDB expectation queued for next cycle
    task automatic step(input string name, input logic r, input logic f, input logic [7:0] v,
                        input logic [7:0] eg, input logic [7:0] es,
                        input logic [3:0] f2, input logic [3:0] f1, input logic [3:0] f0, input logic use1);
        @(posedge clk);
        #1;
        rst       = r;
        flush     = f;
        req_valid = v;
        #1;
        if (use1) begin
            check({name, " grant1"}, cyc, 64'(g1), 64'(eg));
            check({name, " stall1"}, cyc, 64'(s1), 64'(es));
        end else begin
            check({name, " grant"}, cyc, 64'(req_grant), 64'(eg));
            check({name, " stall"}, cyc, 64'(req_stall), 64'(es));
        end
        exp_q.push_back('{due: cyc + 1, dut1: use1, f2: f2, f1: f1, f0: f0});
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_tag[i*TAG_W +: TAG_W]  = tag_of(32'(i));
            req_value[i*XLEN +: XLEN]  = value_of(32'(i));
            req_rob[i*ROB_W +: ROB_W]  = rob_of(32'(i));
        end

        // Reset, then single requester
        step("rst0",  1'b0, 1'b0, 8'h00, 8'h00, 8'h00, NONE, NONE, NONE, 1'b0);
        step("rst1",  1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, NONE, NONE, NONE, 1'b0);
        step("s1",    1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 4'd0, NONE, NONE, 1'b0);
        step("idle",  1'b1, 1'b0, 8'h00, 8'h00, 8'h00, NONE, NONE, NONE, 1'b0);
        // Flush brings rr_ptr to 0, then full load rotates with wrap
        step("fl0",   1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF, NONE, NONE, NONE, 1'b0);
        step("s2a",   1'b1, 1'b0, 8'hFF, 8'h07, 8'hF8, 4'd0, 4'd1, 4'd2, 1'b0);
        step("s2b",   1'b1, 1'b0, 8'hFF, 8'h38, 8'hC7, 4'd3, 4'd4, 4'd5, 1'b0);
        step("s2c",   1'b1, 1'b0, 8'hFF, 8'hC1, 8'h3E, 4'd6, 4'd7, 4'd0, 1'b0);
        // Move rr_ptr to 5, then exactly three valid
        step("s3pre", 1'b1, 1'b0, 8'h10, 8'h10, 8'h00, 4'd4, NONE, NONE, 1'b0);
        step("s3",    1'b1, 1'b0, 8'h92, 8'h92, 8'h00, 4'd7, 4'd1, 4'd4, 1'b0);
        // Flush with full load; rr_ptr must restart at 0
        step("s4",    1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF, NONE, NONE, NONE, 1'b0);
        step("s4chk", 1'b1, 1'b0, 8'hFF, 8'h07, 8'hF8, 4'd0, 4'd1, 4'd2, 1'b0);
        // Reset during activity, also together with flush; rr_ptr must restart at 0
        step("s5a",   1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, NONE, NONE, NONE, 1'b0);
        step("s5b",   1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, NONE, NONE, NONE, 1'b0);
        step("s5c",   1'b1, 1'b0, 8'hFF, 8'h07, 8'hF8, 4'd0, 4'd1, 4'd2, 1'b0);
        step("s5d",   1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 4'd0, NONE, NONE, 1'b0);
        step("s5e",   1'b1, 1'b0, 8'hFF, 8'h0E, 8'hF1, 4'd1, 4'd2, 4'd3, 1'b0);
        step("fl6",   1'b1, 1'b1, 8'h00, 8'h00, 8'h00, NONE, NONE, NONE, 1'b0);
        // Single-slot instance: FU7 waits while FU0..FU3 take turns
        step("s6c1",  1'b1, 1'b0, 8'h81, 8'h01, 8'h80, NONE, NONE, 4'd0, 1'b1);
        step("s6c2",  1'b1, 1'b0, 8'h82, 8'h02, 8'h80, NONE, NONE, 4'd1, 1'b1);
        step("s6c3",  1'b1, 1'b0, 8'h84, 8'h04, 8'h80, NONE, NONE, 4'd2, 1'b1);
        step("s6c4",  1'b1, 1'b0, 8'h88, 8'h08, 8'h80, NONE, NONE, 4'd3, 1'b1);
`ifdef CDB_ARB_STARVE_GUARD_EN
        step("s6c5",  1'b1, 1'b0, 8'h90, 8'h80, 8'h10, NONE, NONE, 4'd7, 1'b1);
`else
        step("s6c5",  1'b1, 1'b0, 8'h90, 8'h10, 8'h80, NONE, NONE, 4'd4, 1'b1);
`endif
        step("s6end", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, NONE, NONE, NONE, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("drain", cyc, 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the NUM_CDB common data bus slots among NUM_REQ functional-unit completion requesters.
- Each cycle it grants up to NUM_CDB requesters using rotating round-robin priority and returns a per-FU stall mask.
- It registers the granted results onto the CDB, with one cycle of latency, for the complete stage and rename/RS wakeup.
- Sits between the FU completion packets and the complete stage.

Parameters:
NUM_REQ, 8, number of FU completion requesters
NUM_CDB, 3, CDB slots per cycle
TAG_W, 6, physical register tag width
ROB_W, 5, ROB index width
XLEN, 32, data width
STARVE_LIMIT, 4, wait cycles before a requester is force-prioritised (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-low (asserted when 0)
flush  in  1  squash: drop pending CDB outputs and grants
req_valid  in  NUM_REQ  FU i holds a completed result
req_tag  in  NUM_REQ*TAG_W  destination physical tag per FU
req_value  in  NUM_REQ*XLEN  result value per FU
req_rob  in  NUM_REQ*ROB_W  ROB entry per FU
req_grant  out  NUM_REQ  combinational; FU i result accepted this cycle
req_stall  out  NUM_REQ  combinational; req_valid & ~req_grant
cdb_valid  out  NUM_CDB  registered slot valid
cdb_tag  out  NUM_CDB*TAG_W  registered broadcast tag
cdb_value  out  NUM_CDB*XLEN  registered writeback value
cdb_rob  out  NUM_CDB*ROB_W  registered ROB index to mark complete

Behaviour:
- Reset (rst==0 at a clk edge):
  - cdb_valid, cdb_tag, cdb_value, cdb_rob = 0.
  - rr_ptr = 0.
  - All wait counters = 0.
  - req_grant and req_stall are forced to 0 while rst==0.
- Requester contract:
  - An FU holds req_valid and its payload stable until it sees req_grant.
  - The arbiter does not buffer requests.
- Grant selection (combinational):
  - Scan requesters in order rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - Grant the first NUM_CDB requesters with req_valid=1.
  - If fewer than NUM_CDB are valid, grant all of them.
- Slot mapping:
  - The k-th grant in scan order (k=0 first) is written to slot NUM_CDB-1-k.
  - Slots with no grant get cdb_valid=0 next cycle; their payload fields are 0.
- Latency:
  - A grant in cycle N appears on cdb_* in cycle N+1.
  - cdb_* holds for exactly one cycle.
- Pointer update:
  - If any grant is made, rr_ptr becomes (index of the last granted requester + 1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged.
  - Wrap from NUM_REQ-1 to 0.
- Flush:
  - If flush==1 in cycle N, req_grant=0 in cycle N and cdb_valid=0 in N+1.
  - rr_ptr and the wait counters are reset to 0.
  - FUs keep their own valid state; the arbiter does not clear it.
- Simultaneous rst==0 and flush: reset wins; the result is identical either way.
- All-idle cycle: cdb_valid=0 and no state change apart from the counters clearing.
- Exactly NUM_CDB requesters valid: all are granted; req_stall=0.
- Width rules: cdb_* fields are copied unmodified from the granted requester; no arithmetic on the payload.

Optional Feature:
- Macro: CDB_ARB_STARVE_GUARD_EN
- Defined:
  - Each requester has a saturating wait counter of width clog2(STARVE_LIMIT+1).
  - The counter increments each cycle the requester is stalled and clears when it is granted or its req_valid=0.
  - A requester whose counter equals STARVE_LIMIT is "urgent".
  - Urgent requesters are granted first, in round-robin order from rr_ptr, and occupy the highest slots.
  - Remaining slots are then filled by the normal scan, skipping requesters already granted.
  - The rr_ptr update uses the last grant from the normal scan; if the normal scan granted nothing, rr_ptr is unchanged.
- Undefined: no counters are present; behaviour is pure round-robin.
- Under the test scenarios below, outputs are identical with and without the macro, except scenario 6.

Test Plan:
1. After reset, req_valid=8'b0000_0001, tag 6'h01, value 32'h12345678, rob 5'd10 -> same cycle req_grant=8'h01; next cycle cdb_valid=3'b100, cdb_tag slot2=6'h01, cdb_value slot2=32'h12345678, cdb_rob slot2=10; rr_ptr=1.
2. rr_ptr=0, req_valid=8'hFF -> grant 8'h07, req_stall=8'hF8, slots 2/1/0 = FU0/1/2. Next cycle with all still valid -> grant 8'h38; then 8'hC1 (wrap), with slot2=FU6, slot1=FU7, slot0=FU0.
3. Exactly three valid (FU1, FU4, FU7), rr_ptr=5 -> grants in order FU7, FU1, FU4 into slots 2, 1, 0; req_stall=0; rr_ptr becomes 5.
4. req_valid=8'hFF with flush=1 -> req_grant=0 that cycle; cdb_valid=0 next cycle; rr_ptr=0.
5. Hold rst=0 during active grants -> cdb_valid=0 on the following cycle and req_grant=0 while rst==0. Release rst -> behaviour matches scenario 1.
6. (Guard enabled, STARVE_LIMIT=4) Keep FU7 valid while FU0-FU6 continuously refill so that FU7 is stalled 4 consecutive cycles -> on the 5th cycle FU7 is granted into slot 2 regardless of rr_ptr. Without the macro, FU7 is granted only when the round-robin scan reaches it.
